// File: rtl/instr_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues busywait-handshake word fetches,
// and buffers returned words against decode stalls with an output reg + 1-entry skid.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_mem_read,
    output logic [31:0] o_mem_address,
    input  logic        i_mem_busywait,
    input  logic [31:0] i_mem_readdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    output logic        o_fetch_error
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_KILL} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0]   r_pc, r_addr, r_instr, r_instr_pc, r_skid, r_skid_pc;
    logic          r_req, r_valid, r_skid_vld, r_err;
    logic [CW-1:0] r_wait_cnt;

    logic [31:0] w_pc_nxt, w_addr_nxt, w_instr_nxt, w_ipc_nxt, w_skid_nxt, w_skid_pc_nxt;
    logic        w_req_nxt, w_valid_nxt, w_skid_vld_nxt;
    logic        w_done, w_hold;
    logic [31:0] w_target;

    assign w_done   = r_req && !i_mem_busywait;
    assign w_hold   = r_req && i_mem_busywait;
    assign w_target = {i_branch_target[31:2], 2'b00};

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_instr_nxt    = r_instr;
        w_ipc_nxt      = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_skid_nxt     = r_skid;
        w_skid_pc_nxt  = r_skid_pc;
        w_skid_vld_nxt = r_skid_vld;

        if (i_branch_taken) begin
            w_valid_nxt    = 1'b0;
            w_skid_vld_nxt = 1'b0;
            w_pc_nxt       = w_target;
            // A still-busy fetch cannot be withdrawn: keep its address up and drain it in KILL.
            if (w_hold) begin
                w_state_nxt = S_KILL;
            end else begin
                w_state_nxt = S_FETCH;
                w_req_nxt   = 1'b1;
                w_addr_nxt  = w_target;
            end
        end else if (r_state == S_KILL) begin
            if (w_done) begin
                w_state_nxt = S_FETCH;
                w_req_nxt   = 1'b1;
                w_addr_nxt  = r_pc;
            end
        end else begin
            if (w_done) begin
                w_pc_nxt = r_pc + 32'd4;
                if (!r_valid || !i_stall) begin
                    w_instr_nxt = i_mem_readdata;
                    w_ipc_nxt   = r_addr;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_skid_nxt     = i_mem_readdata;
                    w_skid_pc_nxt  = r_addr;
                    w_skid_vld_nxt = 1'b1;
                end
            end else if (!i_stall) begin
                w_valid_nxt = r_skid_vld;
                if (r_skid_vld) begin
                    w_instr_nxt    = r_skid;
                    w_ipc_nxt      = r_skid_pc;
                    w_skid_vld_nxt = 1'b0;
                end
            end
            if (w_hold) begin
                w_state_nxt = S_WAIT;
            end else begin
                // Request is registered, so one fetch may land during a stall; the skid absorbs it.
                w_state_nxt = S_FETCH;
                w_req_nxt   = !w_skid_vld_nxt && (!w_valid_nxt || !i_stall);
                w_addr_nxt  = w_pc_nxt;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_skid     <= '0;
            r_skid_pc  <= '0;
            r_skid_vld <= 1'b0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_ipc_nxt;
            r_valid    <= w_valid_nxt;
            r_skid     <= w_skid_nxt;
            r_skid_pc  <= w_skid_pc_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            if (w_done) begin
                r_wait_cnt <= '0;
            end else if (w_hold && r_wait_cnt != CW'(MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
                if (r_wait_cnt == CW'(MAX_WAIT - 1)) r_err <= 1'b1;
            end
        end
    end

    assign o_mem_read    = r_req;
    assign o_mem_address = r_addr;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_valid;
    assign o_fetch_error = r_err;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_ctrl;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, br = 1'b0, busy = 1'b0;
    logic [31:0] tgt = '0;
    logic        mem_read, instr_valid, fetch_error;
    logic [31:0] mem_address, mem_rdata, instr, instr_pc;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign mem_rdata = memf(mem_address);

    instr_fetch_ctrl #(.RESET_PC(32'h0), .MAX_WAIT(MAXW)) dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall),
        .i_branch_taken(br), .i_branch_target(tgt),
        .o_mem_read(mem_read), .o_mem_address(mem_address),
        .i_mem_busywait(busy), .i_mem_readdata(mem_rdata),
        .o_instr(instr), .o_instr_pc(instr_pc),
        .o_instr_valid(instr_valid), .o_fetch_error(fetch_error)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: q holds the PCs visible to decode (front = output, second = skid).
    logic [31:0] m_pc, m_addr;
    bit          m_req, m_kill, m_err;
    int          m_cnt;
    logic [31:0] q[$];

    task automatic model_step();
        bit done, hold;
        done = m_req && !busy;
        hold = m_req && busy;
        if (rst) begin
            m_pc = 32'h0; m_addr = 32'h0; m_req = 0; m_kill = 0;
            m_err = 0; m_cnt = 0; q.delete(); chk_en = 1'b1;
            return;
        end
        if (done) m_cnt = 0;
        else if (hold && m_cnt < MAXW) begin
            m_cnt++;
            if (m_cnt == MAXW) m_err = 1;
        end
        if (br) begin
            q.delete();
            m_pc = {tgt[31:2], 2'b00};
            m_kill = hold;
            if (!hold) begin m_req = 1; m_addr = m_pc; end
        end else if (m_kill) begin
            if (done) begin m_kill = 0; m_req = 1; m_addr = m_pc; end
        end else begin
            if (!stall && q.size() > 0) void'(q.pop_front());
            if (done) begin q.push_back(m_addr); m_pc += 32'd4; end
            if (!hold) begin
                m_req  = (q.size() < 2) && (q.size() == 0 || !stall);
                m_addr = m_pc;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("mem_read", mem_read, m_req);
            if (m_req) chk("mem_address", mem_address, m_addr);
            chk("instr_valid", instr_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("instr_pc", instr_pc, q[0]);
                chk("instr", instr, memf(q[0]));
            end
            chk("fetch_error", fetch_error, m_err);
        end
    end

    // Inputs set just after a rising edge take effect at the next one; returns at the falling edge.
    task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t, input bit bw);
        @(posedge clk);
        #1;
        rst = r; stall = s; br = b; tgt = t; busy = bw;
        @(negedge clk);
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_fetch_error", fetch_error, 0);

        // Zero-wait streaming from reset release.
        step(0, 0, 0, 0, 0);
        chk("rel_mem_read", mem_read, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 0, 0);
            chk("zw_mem_read", mem_read, 1);
            chk("zw_mem_address", mem_address, 32'(4 * (k - 1)));
            chk("zw_instr_valid", instr_valid, k >= 2);
            if (k >= 2) chk("zw_instr_pc", instr_pc, 32'(4 * (k - 2)));
        end

        // Redirect to 0x103 while the fetch of 0x14 is busy: its data must never appear.
        step(0, 0, 0, 0, 1);
        chk("bw_addr", mem_address, 32'h14);
        chk("bw_ipc", instr_pc, 32'h10);
        step(0, 0, 0, 0, 1);
        chk("bw_hold_addr", mem_address, 32'h14);
        step(0, 0, 1, 32'h103, 1);
        chk("bw_hold_addr2", mem_address, 32'h14);
        step(0, 0, 0, 0, 0);
        chk("kill_read", mem_read, 1);
        chk("kill_addr", mem_address, 32'h14);
        chk("kill_valid", instr_valid, 0);
        chk("model_kill_pc", m_pc, 32'h100);
        step(0, 0, 0, 0, 0);
        chk("tgt_addr", mem_address, 32'h100);
        chk("tgt_valid", instr_valid, 0);
        step(0, 0, 0, 0, 0);
        chk("tgt_first_ipc", instr_pc, 32'h100);
        chk("tgt_first_instr", instr, memf(32'h100));
        chk("tgt_first_valid", instr_valid, 1);

        // Stall: in-flight word lands in the skid, outputs freeze, then drain in order.
        step(0, 1, 0, 0, 0);
        chk("st_ipc0", instr_pc, 32'h104);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0, 0);
            chk("st_frozen_ipc", instr_pc, 32'h104);
            chk("st_no_read", mem_read, 0);
        end
        step(0, 0, 0, 0, 0);
        chk("st_last_ipc", instr_pc, 32'h104);
        step(0, 0, 0, 0, 0);
        chk("st_skid_ipc", instr_pc, 32'h108);
        chk("st_reissue", mem_address, 32'h10C);

        // Timeout with MAX_WAIT=4, then reset in the middle of a wait.
        step(0, 0, 0, 0, 1);
        chk("to_ipc", instr_pc, 32'h10C);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 0, 1);
            chk("to_err", fetch_error, k == 4);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("to_sticky", fetch_error, 1);
        chk("to_done_ipc", instr_pc, 32'h110);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("mr_mem_read", mem_read, 0);
        chk("mr_mem_address", mem_address, 0);
        chk("mr_instr", instr, 0);
        chk("mr_instr_pc", instr_pc, 0);
        chk("mr_valid", instr_valid, 0);
        chk("mr_err", fetch_error, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("mr_restart_read", mem_read, 1);
        chk("mr_restart_addr", mem_address, 0);

        // Randomized traffic, including redirects near the top of the address space.
        for (int i = 0; i < 3000; i++) begin
            bit r, s, b, bw;
            logic [31:0] t;
            r  = ($urandom_range(0, 249) == 0);
            s  = ($urandom_range(0, 9) < 3);
            b  = ($urandom_range(0, 19) == 0);
            bw = ($urandom_range(0, 9) < 4);
            t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(r, s, b, t, bw);
        end
        step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences all reads of the instruction memory for the RV32IM pipeline IF stage.
- Owns the PC and issues word fetches over a busywait-style memory handshake.
- Buffers returned instructions against decode-stage stalls using an output register plus a 1-entry skid buffer.
- Handles branch/jump redirects, including squashing a fetch already in flight, and flags memory that never responds.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 64, maximum busywait cycles per fetch before fetch_error is raised.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept; hold the current output.
- branch_taken  input  1  one-cycle redirect request from EX.
- branch_target  input  32  redirect byte address.
- mem_read  output  1  fetch request to instruction memory.
- mem_address  output  32  byte address of the fetch (word-aligned).
- mem_busywait  input  1  memory not ready.
- mem_readdata  input  32  instruction word, valid when mem_read=1 and mem_busywait=0.
- instr  output  32  instruction presented to IF/ID.
- instr_pc  output  32  PC of instr.
- instr_valid  output  1  instr/instr_pc are valid.
- fetch_error  output  1  sticky: a fetch exceeded MAX_WAIT.

Behaviour:
- Reset (synchronous, wins over everything):
  - pc=RESET_PC; state=FETCH.
  - mem_read=0, mem_address=0, instr=0, instr_pc=0, instr_valid=0.
  - Skid buffer empty; wait counter=0; fetch_error=0.
  - A fetch in flight at reset is abandoned. Memory must tolerate mem_read dropping.
- Memory protocol:
  - While mem_read=1, mem_address is held stable.
  - A fetch completes on the rising edge where mem_read=1 and mem_busywait=0. mem_readdata is sampled at that edge.
  - Zero-wait memory gives one fetch per cycle.
- Issue rule: mem_read=1 in FETCH/WAIT when the skid buffer is empty and (instr_valid=0 or stall=0).
- PC update: pc advances by 4 at each completing edge. pc wraps from 32'hFFFF_FFFC to 0 with no flag.
- States:
  - FETCH: request asserted. Completion goes to FETCH; busywait goes to WAIT.
  - WAIT: request held. Completion goes to FETCH; the wait counter increments each busywait cycle.
  - KILL: outstanding fetch being squashed. Address held; completion data is discarded; then go to FETCH at the redirected pc.
- Completion routing:
  - If instr_valid=0 or stall=0: data goes to instr/instr_pc and instr_valid=1 next cycle. One cycle of latency from completion edge to output.
  - If stall=1 and instr_valid=1: data goes to the skid buffer. No new issue until the skid drains.
- Stall release: with the skid full, the skid moves to the output on the first edge with stall=0.
- No new completion when stall=0: instr_valid drops to 0 (bubble).
- Redirect (branch_taken=1 at an edge) has priority over stall and completion:
  - Clear instr_valid and the skid.
  - pc = {branch_target[31:2],2'b00} (low bits forced to zero).
  - If mem_read=1 and mem_busywait=1 at that edge, enter KILL. Otherwise go to FETCH at the target next cycle.
  - A completion on the same edge as the redirect is discarded.
- Redirect while in KILL: pc is updated to the newer target; stay in KILL.
- Timeout:
  - The wait counter resets on each completion.
  - When it reaches MAX_WAIT, fetch_error=1 (sticky until reset).
  - The request remains asserted.

Test Plan:
- Zero-wait memory, reset release: mem_address 0,4,8,… on consecutive cycles. instr_valid=1 from cycle 2 with instr_pc 0,4,8.
- busywait=1 for 3 cycles on address 0x8: address held at 0x8 for 4 cycles, one instr_pc=0x8 output, no duplicate.
- stall=1 for 5 cycles with outstanding fetch: instr/instr_pc frozen, skid captures next word, mem_read=0. Release gives consecutive outputs in order with no loss.
- branch_taken=1, target 0x103 during 2-cycle busywait on 0x20: KILL, 0x20 data never appears. Next issued address is 0x100, first valid instr_pc=0x100.
- branch_taken and stall same cycle with skid full: both entries flushed, fetch at target, instr_valid=0 until target returns.
- MAX_WAIT=4, busywait held: fetch_error=1 after 4 wait cycles, stays 1 after busywait drops. Synchronous reset mid-WAIT clears all outputs to 0 and restarts at RESET_PC.
